// File: rtl/apb_master_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_mux_if
//  Purpose  : Request/response port plus APB bus bundle for apb_master_mux.
//             The master modport is the bridge side, the slave modport is
//             the side that issues requests and models the completers.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_master_mux_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4
);
   // request / response side
   logic                         req_valid;
   logic                         req_ready;
   logic                         req_write;
   logic [ADDR_WIDTH-1:0]        req_addr;
   logic [DATA_WIDTH-1:0]        req_wdata;
   logic [DATA_WIDTH/8-1:0]      req_strb;
   logic                         rsp_valid;
   logic [DATA_WIDTH-1:0]        rsp_rdata;
   logic                         rsp_err;
   // APB side
   logic [NUM_SLAVES-1:0]        PSEL;
   logic                         PENABLE;
   logic                         PWRITE;
   logic [ADDR_WIDTH-1:0]        PADDR;
   logic [DATA_WIDTH-1:0]        PWDATA;
   logic [DATA_WIDTH/8-1:0]      PSTRB;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
   logic [NUM_SLAVES-1:0]        PREADY;
   logic [NUM_SLAVES-1:0]        PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/apb_master_mux.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_mux
//  Purpose  : APB master that turns single request/response transfers into
//             APB SETUP/ACCESS cycles towards NUM_SLAVES completers selected
//             by the top address bits. Reports slave errors, decode errors
//             and ACCESS-phase timeouts on rsp_err.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_mux #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SEL_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire logic          PCLK,
   input  wire logic          PRESET,
   apb_master_mux_if.master   bus
);

   localparam int                  c_strb_w  = DATA_WIDTH / 8;
   localparam int                  c_cnt_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
   localparam bit                  c_to_en   = (TIMEOUT_CYCLES != 0);
   localparam logic [SEL_BITS:0]   c_num_slv = (SEL_BITS + 1)'(NUM_SLAVES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DERR   = 2'd3
   } state_t;

   state_t                   r_state;
   logic [NUM_SLAVES-1:0]    r_psel;
   logic                     r_penable;
   logic                     r_pwrite;
   logic [ADDR_WIDTH-1:0]    r_paddr;
   logic [DATA_WIDTH-1:0]    r_pwdata;
   logic [c_strb_w-1:0]      r_pstrb;
   logic                     r_rsp_valid;
   logic [DATA_WIDTH-1:0]    r_rsp_rdata;
   logic                     r_rsp_err;
   logic [c_cnt_w-1:0]       r_cnt;

   logic                     w_sel_ready;
   logic                     w_sel_err;
   logic [DATA_WIDTH-1:0]    w_sel_rdata;
   logic                     w_timeout;
   logic                     w_req_ready;
   logic                     w_accept;
   logic [SEL_BITS-1:0]      w_req_idx;
   logic                     w_req_hit;
   logic [NUM_SLAVES-1:0]    w_req_onehot;

   // PSEL is one-hot while a transfer is on the bus, so masking with it
   // selects the active completer and ignores all the others.
   assign w_sel_ready = |(bus.PREADY  & r_psel);
   assign w_sel_err   = |(bus.PSLVERR & r_psel);

   // Read-data mux driven by the registered one-hot select.
   always_comb begin
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_psel[i]) begin
            w_sel_rdata = w_sel_rdata | bus.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Timeout fires on the last allowed ACCESS cycle only if PREADY stays low.
   assign w_timeout   = c_to_en && (r_state == S_ACCESS) && (r_cnt == c_cnt_last) && !w_sel_ready;
   assign w_req_ready = (r_state == S_IDLE) ||
                        ((r_state == S_ACCESS) && w_sel_ready && !w_timeout);
   assign w_accept    = bus.req_valid && w_req_ready;

   assign w_req_idx   = bus.req_addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign w_req_hit   = ({1'b0, w_req_idx} < c_num_slv);

   // Decode the incoming slave index into a one-hot select.
   always_comb begin
      w_req_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_req_onehot[i] = (w_req_idx == i[SEL_BITS-1:0]);
      end
   end

   // Transfer FSM with registered APB and response outputs. Acceptance is
   // handled after the case so a back-to-back request overrides the
   // return-to-IDLE of a completing ACCESS.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= S_IDLE;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_IDLE;
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (w_sel_ready) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_sel_err;
                  r_rsp_rdata <= r_pwrite ? '0 : w_sel_rdata;
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DERR: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_accept) begin
            r_paddr   <= bus.req_addr;
            r_pwrite  <= bus.req_write;
            r_pwdata  <= bus.req_wdata;
            r_pstrb   <= bus.req_write ? bus.req_strb : '0;
            r_penable <= 1'b0;
            if (w_req_hit) begin
               r_psel  <= w_req_onehot;
               r_state <= S_SETUP;
            end else begin
               r_psel  <= '0;
               r_state <= S_DERR;
            end
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.PSEL      = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PADDR     = r_paddr;
   assign bus.PWDATA    = r_pwdata;
   assign bus.PSTRB     = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_mux
//  Purpose  : Self-checking bench for apb_master_mux with a configurable
//             completer model and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_mux;

   localparam int c_ns = 4;
   localparam int c_to = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   apb_master_mux_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(c_ns)) u_if ();

   apb_master_mux #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(c_ns),
      .SEL_BITS(4), .TIMEOUT_CYCLES(c_to)
   ) u_dut (
      .PCLK   (clk),
      .PRESET (rst),
      .bus    (u_if.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // completer configuration
   int          wait_cfg [c_ns];
   bit          hang_cfg [c_ns];
   bit          err_cfg  [c_ns];
   logic [31:0] rd_cfg   [c_ns];
   int          acc_cnt;

   // Selected completer answers after wait_cfg ACCESS cycles; unselected
   // ones hold PREADY high and drive their own data/error to be ignored.
   always_comb begin
      for (int i = 0; i < c_ns; i++) begin
         u_if.PREADY[i]            = u_if.PSEL[i] ? (u_if.PENABLE && !hang_cfg[i] && (acc_cnt >= wait_cfg[i])) : 1'b1;
         u_if.PSLVERR[i]           = err_cfg[i];
         u_if.PRDATA[i*32 +: 32]   = rd_cfg[i];
      end
   end

   // Count completed wait cycles inside the current ACCESS phase.
   always @(posedge clk) begin
      if (rst || !u_if.PENABLE || (|(u_if.PREADY & u_if.PSEL))) acc_cnt <= 0;
      else                                                      acc_cnt <= acc_cnt + 1;
   end

   // per-cycle history of one transfer, index 1 = first cycle after accept
   logic [3:0]  psel_h  [64];
   logic        pen_h   [64];
   logic        pwr_h   [64];
   logic [3:0]  pstrb_h [64];
   logic [31:0] paddr_h [64];
   logic [31:0] pwd_h   [64];

   task automatic rec(input int n);
      psel_h[n]  = u_if.PSEL;
      pen_h[n]   = u_if.PENABLE;
      pwr_h[n]   = u_if.PWRITE;
      pstrb_h[n] = u_if.PSTRB;
      paddr_h[n] = u_if.PADDR;
      pwd_h[n]   = u_if.PWDATA;
   endtask

   task automatic drive_req(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
      u_if.req_valid = 1'b1;
      u_if.req_write = wr;
      u_if.req_addr  = a;
      u_if.req_wdata = wd;
      u_if.req_strb  = s;
   endtask

   // Reference model: outcome of one isolated transfer from the decode,
   // completer configuration and timeout rules.
   function automatic void model(input bit wr, input logic [31:0] addr,
                                 output logic [31:0] rd, output bit err, output int lat);
      int idx;
      idx = int'(addr[31:28]);
      if (idx >= c_ns) begin
         rd = 0; err = 1; lat = 2;
      end else if (hang_cfg[idx] || wait_cfg[idx] >= c_to) begin
         rd = 0; err = 1; lat = 2 + c_to;
      end else begin
         rd = wr ? 32'h0 : rd_cfg[idx]; err = err_cfg[idx]; lat = 3 + wait_cfg[idx];
      end
   endfunction

   // One isolated transfer; returns response and cycles from accept to rsp_valid.
   task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                       output logic [31:0] rd, output bit err, output int lat, output bit to);
      int n;
      to = 0; lat = 0; rd = 0; err = 0; n = 0;
      @(negedge clk);
      drive_req(wr, a, wd, s);
      while (!u_if.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         u_if.req_valid = 1'b0;
         to = 1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      u_if.req_valid = 1'b0;
      u_if.req_write = 1'($urandom);
      u_if.req_addr  = $urandom;
      u_if.req_wdata = $urandom;
      u_if.req_strb  = 4'($urandom);
      n = 1;
      rec(n);
      while (!u_if.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
         rec(n);
      end
      if (!u_if.rsp_valid) begin
         to = 1;
         return;
      end
      lat = n;
      rd  = u_if.rsp_rdata;
      err = u_if.rsp_err;
   endtask

   task automatic cfg_clear();
      for (int i = 0; i < c_ns; i++) begin
         wait_cfg[i] = 0; hang_cfg[i] = 0; err_cfg[i] = 1; rd_cfg[i] = 32'hA5A5_0000 + i;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (u_if.PSEL !== 4'b0 || u_if.PENABLE !== 1'b0) begin bad++; $display("FAIL reset_apb: psel=%b pen=%b want 0/0", u_if.PSEL, u_if.PENABLE); end
      total++; if (u_if.rsp_valid !== 1'b0 || u_if.rsp_err !== 1'b0 || u_if.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp: v=%b e=%b d=%h want 0", u_if.rsp_valid, u_if.rsp_err, u_if.rsp_rdata); end
      total++; if (u_if.PADDR !== 32'h0 || u_if.PWDATA !== 32'h0 || u_if.PSTRB !== 4'h0 || u_if.PWRITE !== 1'b0) begin bad++; $display("FAIL reset_regs: a=%h d=%h s=%h w=%b want 0", u_if.PADDR, u_if.PWDATA, u_if.PSTRB, u_if.PWRITE); end
      rst = 1'b0;
      total++; if (u_if.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", u_if.req_ready); end
   endtask

   task automatic test_write_zero_wait();
      logic [31:0] rd; bit err, to; int lat;
      cfg_clear();
      err_cfg[1] = 0;
      xfer(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, rd, err, lat, to);
      total++; if (to || lat != 3) begin bad++; $display("FAIL wr_latency: got %0d (to=%0d) want 3", lat, to); end
      total++; if (err !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL wr_rsp: err=%b rd=%h want 0/0", err, rd); end
      total++; if (psel_h[1] !== 4'b0010 || psel_h[2] !== 4'b0010 || psel_h[3] !== 4'b0000) begin bad++; $display("FAIL wr_psel: %b %b %b want 0010 0010 0000", psel_h[1], psel_h[2], psel_h[3]); end
      total++; if (pen_h[1] !== 1'b0 || pen_h[2] !== 1'b1) begin bad++; $display("FAIL wr_penable: %b %b want 0 1", pen_h[1], pen_h[2]); end
      total++; if (pwr_h[1] !== 1'b1 || pstrb_h[1] !== 4'hF || paddr_h[2] !== 32'h1000_0010 || pwd_h[2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_fields: w=%b s=%h a=%h d=%h", pwr_h[1], pstrb_h[1], paddr_h[2], pwd_h[2]); end
   endtask

   task automatic test_read_wait();
      logic [31:0] rd; bit err, to; int lat, acc;
      cfg_clear();
      wait_cfg[2] = 3; err_cfg[2] = 0; rd_cfg[2] = 32'h1234_5678;
      xfer(0, 32'h2000_0000, 32'h0, 4'hF, rd, err, lat, to);
      acc = 0;
      for (int n = 1; n <= lat; n++) if (pen_h[n]) acc++;
      total++; if (to || lat != 6 || acc != 4) begin bad++; $display("FAIL rd_wait_latency: lat=%0d access=%0d want 6/4", lat, acc); end
      total++; if (rd !== 32'h1234_5678 || err !== 1'b0) begin bad++; $display("FAIL rd_wait_data: rd=%h err=%b want 12345678/0", rd, err); end
      total++; if (pstrb_h[1] !== 4'h0 || psel_h[1] !== 4'b0100 || pwr_h[1] !== 1'b0) begin bad++; $display("FAIL rd_wait_fields: s=%h psel=%b w=%b want 0/0100/0", pstrb_h[1], psel_h[1], pwr_h[1]); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ps [9];
      logic        rv [9];
      logic [31:0] rdd[9];
      logic        er [9];
      logic [3:0]  exp_ps [9];
      bit pend;
      int acc_n;
      cfg_clear();
      err_cfg[0] = 0; err_cfg[3] = 0; rd_cfg[3] = $urandom;
      exp_ps[1] = 4'b0001; exp_ps[2] = 4'b0001; exp_ps[3] = 4'b1000; exp_ps[4] = 4'b1000;
      for (int n = 5; n <= 8; n++) exp_ps[n] = 4'b0000;
      @(negedge clk);
      total++; if (u_if.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready: got %b want 1", u_if.req_ready); end
      drive_req(1, 32'h0000_0004, 32'hCAFE_F00D, 4'h3);
      @(posedge clk);
      @(negedge clk);
      drive_req(0, 32'h3000_0008, 32'h0, 4'hF);
      pend = 0; acc_n = 0;
      for (int n = 1; n <= 8; n++) begin
         if (n > 1) @(negedge clk);
         if (pend) begin u_if.req_valid = 1'b0; pend = 0; end
         ps[n] = u_if.PSEL; rv[n] = u_if.rsp_valid; rdd[n] = u_if.rsp_rdata; er[n] = u_if.rsp_err;
         if (u_if.req_valid && u_if.req_ready) begin pend = 1; acc_n = n; end
      end
      u_if.req_valid = 1'b0;
      total++; if (acc_n != 2) begin bad++; $display("FAIL b2b_accept_cycle: got %0d want 2", acc_n); end
      for (int n = 1; n <= 8; n++) begin
         total++; if (ps[n] !== exp_ps[n]) begin bad++; $display("FAIL b2b_psel[%0d]: got %b want %b", n, ps[n], exp_ps[n]); end
         total++; if (rv[n] !== ((n == 3) || (n == 5))) begin bad++; $display("FAIL b2b_rsp_valid[%0d]: got %b want %b", n, rv[n], (n == 3) || (n == 5)); end
      end
      total++; if (rdd[3] !== 32'h0 || er[3] !== 1'b0) begin bad++; $display("FAIL b2b_rsp1: rd=%h err=%b want 0/0", rdd[3], er[3]); end
      total++; if (rdd[5] !== rd_cfg[3] || er[5] !== 1'b0) begin bad++; $display("FAIL b2b_rsp2: rd=%h err=%b want %h/0", rdd[5], er[5], rd_cfg[3]); end
   endtask

   task automatic test_decode_err();
      logic [31:0] rd; bit err, to; int lat;
      cfg_clear();
      xfer(0, 32'hF000_0000, 32'h0, 4'hF, rd, err, lat, to);
      total++; if (to || lat != 2) begin bad++; $display("FAIL derr_latency: got %0d want 2", lat); end
      total++; if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL derr_rsp: err=%b rd=%h want 1/0", err, rd); end
      total++; if (psel_h[1] !== 4'b0 || psel_h[2] !== 4'b0 || pen_h[1] !== 1'b0 || pen_h[2] !== 1'b0) begin bad++; $display("FAIL derr_bus: psel %b %b pen %b %b want idle", psel_h[1], psel_h[2], pen_h[1], pen_h[2]); end
   endtask

   task automatic test_slverr();
      logic [31:0] rd; bit err, to; int lat;
      cfg_clear();
      wait_cfg[0] = 1; err_cfg[0] = 1;
      xfer(0, 32'h0000_0100, 32'h0, 4'hF, rd, err, lat, to);
      total++; if (to || lat != 4 || err !== 1'b1) begin bad++; $display("FAIL slverr: lat=%0d err=%b want 4/1", lat, err); end
   endtask

   task automatic test_timeout();
      logic [31:0] rd; bit err, to; int lat, acc;
      cfg_clear();
      hang_cfg[2] = 1; err_cfg[2] = 0;
      xfer(0, 32'h2000_0040, 32'h0, 4'hF, rd, err, lat, to);
      acc = 0;
      for (int n = 1; n <= lat; n++) if (pen_h[n]) acc++;
      total++; if (to || lat != 2 + c_to || acc != c_to) begin bad++; $display("FAIL timeout_len: lat=%0d access=%0d want %0d/%0d", lat, acc, 2 + c_to, c_to); end
      total++; if (err !== 1'b1 || rd !== 32'h0 || psel_h[lat] !== 4'b0) begin bad++; $display("FAIL timeout_rsp: err=%b rd=%h psel=%b want 1/0/0", err, rd, psel_h[lat]); end
   endtask

   task automatic test_reset_abort();
      int seen;
      cfg_clear();
      hang_cfg[2] = 1;
      @(negedge clk);
      drive_req(0, 32'h2000_0000, 32'h0, 4'hF);
      @(posedge clk);
      @(negedge clk);
      u_if.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (u_if.PENABLE !== 1'b1 || u_if.PSEL !== 4'b0100) begin bad++; $display("FAIL abort_pre: pen=%b psel=%b want 1/0100", u_if.PENABLE, u_if.PSEL); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (u_if.PSEL !== 4'b0 || u_if.PENABLE !== 1'b0 || u_if.rsp_valid !== 1'b0 || u_if.req_ready !== 1'b1) begin bad++; $display("FAIL abort_post: psel=%b pen=%b v=%b rdy=%b want 0/0/0/1", u_if.PSEL, u_if.PENABLE, u_if.rsp_valid, u_if.req_ready); end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (u_if.rsp_valid) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL abort_no_rsp: got %0d pulses want 0", seen); end
   endtask

   task automatic test_random();
      logic [31:0] rd, exp_rd, a, wd; logic [3:0] s; bit err, exp_err, to, wr; int lat, exp_lat, idx;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < c_ns; i++) begin
            wait_cfg[i] = $urandom_range(0, 9);
            hang_cfg[i] = ($urandom_range(0, 7) == 0);
            err_cfg[i]  = 1'($urandom);
            rd_cfg[i]   = $urandom;
         end
         idx = (($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3));
         a   = {4'(idx), 28'($urandom)};
         wd  = $urandom; s = 4'($urandom); wr = 1'($urandom);
         model(wr, a, exp_rd, exp_err, exp_lat);
         xfer(wr, a, wd, s, rd, err, lat, to);
         total++; if (to || lat != exp_lat || err !== exp_err || rd !== exp_rd) begin bad++; $display("FAIL rand[%0d]_rsp: lat=%0d err=%b rd=%h want %0d/%b/%h", k, lat, err, rd, exp_lat, exp_err, exp_rd); end
         if (idx < c_ns) begin
            total++; if (psel_h[1] !== 4'(1 << idx) || pwr_h[1] !== wr || pstrb_h[1] !== (wr ? s : 4'h0) || paddr_h[1] !== a || pwd_h[1] !== wd) begin bad++; $display("FAIL rand[%0d]_bus: psel=%b w=%b s=%h a=%h d=%h", k, psel_h[1], pwr_h[1], pstrb_h[1], paddr_h[1], pwd_h[1]); end
         end else begin
            total++; if (psel_h[1] !== 4'b0) begin bad++; $display("FAIL rand[%0d]_derr_psel: got %b want 0", k, psel_h[1]); end
         end
         @(negedge clk);
         total++; if (u_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL rand[%0d]_pulse: rsp_valid stayed high", k); end
      end
   endtask

   initial begin
      total = 0; bad = 0; rst = 1'b1;
      u_if.req_valid = 1'b0; u_if.req_write = 1'b0; u_if.req_addr = '0; u_if.req_wdata = '0; u_if.req_strb = '0;
      cfg_clear();
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_back_to_back();
      test_decode_err();
      test_slverr();
      test_timeout();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
